dpram_pipe: RTL
===============

DPRAM_PIPE -- requirements
Module: dpram_pipe

Interface
REQ-001 SHALL have parameter AWIDTH, default 13, word-address bits.
REQ-002 SHALL have parameter DEPTH, default 1<<AWIDTH, words implemented (DEPTH <= 2^AWIDTH).
REQ-003 SHALL have parameter DWIDTH, default 32, data bits; multiple of 8; BYTES=DWIDTH/8 a power of two.
REQ-004 SHALL have parameter WRITE_RSP, default 0; 1 = writes also return a response beat.
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port clk  in  1  rising-edge clock.
REQ-007 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-008 SHALL have, per port p in {0,1}, tp_valid in 1, tp_ready out 1, tp_we in 1, tp_size in 2, tp_addr in 32 (byte address), tp_data in DWIDTH (lane-replicated write data).
REQ-009 SHALL have, per port p, ip_valid out 1, ip_ready in 1, ip_data out DWIDTH, ip_error out 1.

Function
REQ-010 SHALL accept a command on port p in a cycle where tp_valid && tp_ready; both ports are independent and may accept in the same cycle.
REQ-011 SHALL derive word index = addr[AWIDTH+log2(BYTES)-1 : log2(BYTES)] and byte offset = addr[log2(BYTES)-1:0].
REQ-012 SHALL map size 0/1/2 to 1/2/4 bytes; byte-enable = contiguous mask at byte offset; sizes wider than BYTES are misaligned.
REQ-013 SHALL flag misaligned (offset not a multiple of size bytes) commands: no write, response with ip_error=1 and ip_data=0.
REQ-014 SHALL return read data exactly one cycle after acceptance when the response buffer is empty and ip_ready=1 (latency 1).
REQ-015 SHALL return the full aligned word on reads; sub-word extraction is the master's job.
REQ-016 SHALL, with WRITE_RSP=0, produce no response for writes; with WRITE_RSP=1, a response with ip_data=0, ip_error per REQ-013.
REQ-017 SHALL hold a 2-entry response buffer per port; occ = in-flight + buffered responses (0..2).
REQ-018 SHALL drive tp_ready = (occ != 2); sustained 1 command/cycle/port when ip_ready=1.
REQ-019 SHALL hold ip_valid, ip_data, ip_error stable while ip_valid && !ip_ready; responses in acceptance order.
REQ-020 SHALL, on same-cycle writes from both ports to one word, write port-1 lanes where masks overlap and each port's lanes elsewhere.
REQ-021 SHALL, on same-cycle read and write to one word, return pre-write data (read-before-write).
REQ-022 SHALL leave memory contents undefined at power-up; reset SHALL NOT clear the array.

Reset
REQ-023 SHALL, while reset_n=0, force ip_valid=0, ip_error=0, ip_data=0, tp_ready=0, occ=0.
REQ-024 SHALL drop in-flight and buffered responses on reset assertion mid-operation; writes already accepted SHALL have completed.
REQ-025 SHALL raise tp_ready on the first clk edge after reset_n deasserts.

Configuration
REQ-026 SHALL, with DPRAM_BOUNDS_CHECK_EN defined, treat word index >= DEPTH or nonzero addr bits above the window as an error: no write, ip_error=1, ip_data=0.
REQ-027 SHALL, without DPRAM_BOUNDS_CHECK_EN, ignore upper address bits (aliasing modulo DEPTH) and report only misalignment errors.

Structure
REQ-028 SHALL place the size encoding (SIZE_BYTE=0, SIZE_HALF=1, SIZE_WORD=2) and the byte-enable/misalignment function in package dpram_pkg.
REQ-029 SHALL implement the per-port response buffer as sub-module dpram_rsp_buf (2-entry FIFO, data+error), instantiated twice.

Verification
REQ-030 SHALL cover: t1 write word 0x0000_0010 data 0xDEADBEEF, then t0 read 0x10 -> i0_data=0xDEADBEEF one cycle after accept.
REQ-031 SHALL cover: t1 byte write size 0 addr 0x13 data 0xAAAAAAAA over 0x00000000 -> read 0x10 returns 0xAA000000.
REQ-032 SHALL cover: i0_ready=0, three back-to-back t0 reads -> two accepted, t0_ready=0 on third, data held stable, order preserved after i0_ready=1.
REQ-033 SHALL cover: same-cycle writes to 0x20, t0 word 0x11111111, t1 half at 0x20 0x2222 -> word reads 0x11112222.
REQ-034 SHALL cover: size 2 at addr 0x22 -> ip_error=1, data 0, memory unchanged; with DPRAM_BOUNDS_CHECK_EN and AWIDTH=13, read 0x8000 -> error, without -> aliases to 0x0.
REQ-035 SHALL cover: reset_n pulsed low with 2 responses buffered -> ip_valid=0 immediately, no stale beat after release.

Source files
------------

// File: rtl/dpram_pkg.sv
// ============================================================================
// Module  : dpram_pkg
// Purpose : Shared definitions for dpram_pipe: transfer-size encoding and the
//           lane-select helpers (byte-enable mask, misalignment test).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package dpram_pkg;

  // Transfer size encoding carried on tp_size; bytes = 1 << size.
  typedef enum logic [1:0] {
    SIZE_BYTE  = 2'd0,
    SIZE_HALF  = 2'd1,
    SIZE_WORD  = 2'd2,
    SIZE_DWORD = 2'd3
  } size_e;

  // Widest data path the lane helpers can describe (DWIDTH <= 512).
  localparam int MAX_BYTES = 64;

  // A transfer is misaligned when it is wider than the data path or its
  // offset inside the word is not a multiple of its own size.
  function automatic logic lane_misaligned(input logic [1:0] size,
                                           input logic [7:0] offset,
                                           input int         bytes);
    int nb;
    nb = 1 << size;
    return (nb > bytes) || ((int'(offset) % nb) != 0);
  endfunction

  // Contiguous byte-enable mask of (1 << size) lanes starting at offset.
  function automatic logic [MAX_BYTES-1:0] lane_mask(input logic [1:0] size,
                                                     input logic [7:0] offset);
    logic [MAX_BYTES-1:0] m;
    int nb;
    nb = 1 << size;
    m  = '0;
    for (int b = 0; b < MAX_BYTES; b++) begin
      m[b] = (b >= int'(offset)) && (b < int'(offset) + nb);
    end
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dpram_rsp_buf.sv
// ============================================================================
// Module  : dpram_rsp_buf
// Purpose : Two-entry response FIFO (data + error) with flow-through: when
//           empty, an incoming beat is presented on the output in the same
//           cycle and only stored if the consumer is not ready.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module dpram_rsp_buf #(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DWIDTH-1:0] push_data,
  input  logic              push_error,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_error,
  output logic [1:0]        count
);

  logic [1:0][DWIDTH-1:0] data_q;
  logic [1:0]             err_q;
  logic                   wr_ptr;
  logic                   rd_ptr;
  logic                   empty;
  logic                   store;
  logic                   drain;

  assign empty     = (count == 2'd0);
  assign out_valid = ~empty | push;
  assign out_data  = empty ? push_data  : data_q[rd_ptr];
  assign out_error = empty ? push_error : err_q[rd_ptr];

  // A beat that bypasses an empty buffer and is taken at once is never stored.
  assign store = push & ~(empty & out_ready);
  assign drain = ~empty & out_ready;

  // Storage, pointers and occupancy; all cleared so reset drops every beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
      err_q  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (store) begin
        data_q[wr_ptr] <= push_data;
        err_q[wr_ptr]  <= push_error;
        wr_ptr         <= ~wr_ptr;
      end
      if (drain) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, store} - {1'b0, drain};
    end
  end

endmodule

`default_nettype wire

// File: rtl/dpram_pipe.sv
// ============================================================================
// Module  : dpram_pipe
// Purpose : Dual-port word RAM with byte/half/word accesses, valid/ready
//           command and response handshakes, latency-1 reads and a 2-entry
//           response buffer per port.
// Config  : define DPRAM_BOUNDS_CHECK_EN to flag out-of-window addresses as
//           errors; otherwise upper address bits alias modulo DEPTH.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module dpram_pipe
  import dpram_pkg::*;
#(
  parameter int AWIDTH    = 13,
  parameter int DEPTH     = 1 << AWIDTH,
  parameter int DWIDTH    = 32,
  parameter int WRITE_RSP = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  // port 0 command
  input  logic              t0_valid,
  output logic              t0_ready,
  input  logic              t0_we,
  input  logic [1:0]        t0_size,
  input  logic [31:0]       t0_addr,
  input  logic [DWIDTH-1:0] t0_data,
  // port 0 response
  output logic              i0_valid,
  input  logic              i0_ready,
  output logic [DWIDTH-1:0] i0_data,
  output logic              i0_error,
  // port 1 command
  input  logic              t1_valid,
  output logic              t1_ready,
  input  logic              t1_we,
  input  logic [1:0]        t1_size,
  input  logic [31:0]       t1_addr,
  input  logic [DWIDTH-1:0] t1_data,
  // port 1 response
  output logic              i1_valid,
  input  logic              i1_ready,
  output logic [DWIDTH-1:0] i1_data,
  output logic              i1_error
);

  localparam int BYTES = DWIDTH / 8;
  localparam int LB    = $clog2(BYTES);

  // Port-indexed views of the two independent ports.
  logic [1:0]             t_valid;
  logic [1:0]             t_we;
  logic [1:0]             t_ready;
  logic [1:0][1:0]        t_size;
  logic [1:0][31:0]       t_addr;
  logic [1:0][DWIDTH-1:0] t_data;
  logic [1:0]             i_valid;
  logic [1:0]             i_ready;
  logic [1:0]             i_error;
  logic [1:0][DWIDTH-1:0] i_data;

  assign t_valid = {t1_valid, t0_valid};
  assign t_we    = {t1_we, t0_we};
  assign t_size  = {t1_size, t0_size};
  assign t_addr  = {t1_addr, t0_addr};
  assign t_data  = {t1_data, t0_data};
  assign i_ready = {i1_ready, i0_ready};

  assign t0_ready = t_ready[0];
  assign t1_ready = t_ready[1];
  assign i0_valid = i_valid[0];
  assign i1_valid = i_valid[1];
  assign i0_data  = i_data[0];
  assign i1_data  = i_data[1];
  assign i0_error = i_error[0];
  assign i1_error = i_error[1];

  logic [1:0]             wr_fire;
  logic [1:0][AWIDTH-1:0] widx;
  logic [1:0][BYTES-1:0]  be;
  logic                   ready_en;

  // Contents are not reset; only the control path is.
  logic [DWIDTH-1:0] mem [DEPTH];

  // Command acceptance opens on the first clock edge after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
    end
  end

  // Byte-lane writes from both ports; port 1 is applied last so it wins
  // lanes that both ports write to the same word in the same cycle.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wr_fire[p] && be[p][b]) begin
          mem[widx[p]][8*b +: 8] <= t_data[p][8*b +: 8];
        end
      end
    end
  end

  generate
    for (genvar p = 0; p < 2; p++) begin : g_port
      logic [7:0]        offset;
      logic [AWIDTH-1:0] idx;
      logic              misaligned;
      logic              oob;
      logic              err;
      logic              accept;
      logic              is_read;
      logic              needs_rsp;
      logic              infl_valid;
      logic              infl_err;
      logic              infl_rd;
      logic [DWIDTH-1:0] rdata;
      logic [DWIDTH-1:0] rsp_data;
      logic [1:0]        buf_count;
      logic [1:0]        occ;

      assign offset     = 8'(t_addr[p] & 32'(BYTES - 1));
      assign idx        = AWIDTH'(t_addr[p] >> LB);
      assign misaligned = lane_misaligned(t_size[p], offset, BYTES);

`ifdef DPRAM_BOUNDS_CHECK_EN
      assign oob = ((t_addr[p] >> (AWIDTH + LB)) != 32'd0) || (int'(idx) >= DEPTH);
`else
      // Upper address bits are deliberately ignored so the window aliases.
      logic unused_upper_addr;
      assign oob               = 1'b0;
      assign unused_upper_addr = ^t_addr[p];
`endif

      assign err        = misaligned | oob;
      assign widx[p]    = AWIDTH'(int'(idx) % DEPTH);
      assign be[p]      = BYTES'(lane_mask(t_size[p], offset));
      assign accept     = t_valid[p] & t_ready[p];
      assign is_read    = accept & ~t_we[p] & ~err;
      assign wr_fire[p] = accept & t_we[p] & ~err;
      // Reads and errored commands always answer; clean writes only if asked.
      assign needs_rsp  = accept & (~t_we[p] | err | (WRITE_RSP != 0));

      // In-flight stage: the array is sampled on the accepting edge, so a
      // same-edge write from either port is not yet visible (read-before-write).
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          infl_valid <= 1'b0;
          infl_err   <= 1'b0;
          infl_rd    <= 1'b0;
          rdata      <= '0;
        end else begin
          infl_valid <= needs_rsp;
          infl_err   <= needs_rsp & err;
          infl_rd    <= is_read;
          if (is_read) begin
            rdata <= mem[widx[p]];
          end
        end
      end

      assign rsp_data = infl_rd ? rdata : '0;

      dpram_rsp_buf #(
        .DWIDTH (DWIDTH)
      ) u_rsp_buf (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (infl_valid),
        .push_data  (rsp_data),
        .push_error (infl_err),
        .out_valid  (i_valid[p]),
        .out_ready  (i_ready[p]),
        .out_data   (i_data[p]),
        .out_error  (i_error[p]),
        .count      (buf_count)
      );

      // Occupancy counts the in-flight beat plus buffered beats.
      assign occ        = {1'b0, infl_valid} + buf_count;
      assign t_ready[p] = ready_en & (occ != 2'd2);
    end
  endgenerate

endmodule

`default_nettype wire
